// File: rtl/beam_pkg.sv
// Shared types for the beam merge/demux pair: arbitration mode, FSM state
// and source-id helpers.
package beam_pkg;

    typedef enum logic [1:0] {
        ROUNDROBIN = 2'b00,
        SRC1       = 2'b01,
        SRC2       = 2'b10,
        SRC3       = 2'b11
    } beam_mode_e;

    typedef enum logic {
        IDLE = 1'b0,
        PASS = 1'b1
    } beam_state_e;

    // Source ids are 1..3 so they can go straight onto tdest; 0 means none.
    function automatic logic [1:0] onehot_to_id(input logic [2:0] oh);
        case (oh)
            3'b001:  return 2'd1;
            3'b010:  return 2'd2;
            3'b100:  return 2'd3;
            default: return 2'd0;
        endcase
    endfunction

    function automatic logic [2:0] id_to_onehot(input logic [1:0] id);
        case (id)
            2'd1:    return 3'b001;
            2'd2:    return 3'b010;
            2'd3:    return 3'b100;
            default: return 3'b000;
        endcase
    endfunction

endpackage

// File: rtl/beam_rr_arb.sv
// Packet-level winner selection: round-robin from last_grant + 1, or a
// single fixed source that wins only while it is valid.
module beam_rr_arb
    import beam_pkg::*;
(
    input  logic [2:0] valid,
    input  beam_mode_e mode,
    input  logic [1:0] last_grant,
    output logic [2:0] grant
);

    logic [1:0] start;
    logic [2:0] rot;
    logic [2:0] pick;
    logic [2:0] rr_grant;

    always_comb begin
        // Rotate so the highest-priority source sits at bit 0, pick, rotate back.
        start = (last_grant == 2'd1 || last_grant == 2'd2) ? last_grant : 2'd0;

        case (start)
            2'd1:    rot = {valid[0], valid[2:1]};
            2'd2:    rot = {valid[1:0], valid[2]};
            default: rot = valid;
        endcase

        if (rot[0])      pick = 3'b001;
        else if (rot[1]) pick = 3'b010;
        else if (rot[2]) pick = 3'b100;
        else             pick = 3'b000;

        case (start)
            2'd1:    rr_grant = {pick[1:0], pick[2]};
            2'd2:    rr_grant = {pick[0], pick[2:1]};
            default: rr_grant = pick;
        endcase

        case (mode)
            SRC1:    grant = {2'b00, valid[0]};
            SRC2:    grant = {1'b0, valid[1], 1'b0};
            SRC3:    grant = {valid[2], 2'b00};
            default: grant = rr_grant;
        endcase
    end

endmodule

// File: rtl/beam_merge.sv
// Merges three ADC AXIS streams into one, arbitrating per packet and
// force-terminating packets that reach MAX_BEATS.
module beam_merge
    import beam_pkg::*;
#(
    parameter int DWIDTH    = 32,
    parameter int MAX_BEATS = 2048
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [1:0]        src_sel,
    input  logic [DWIDTH-1:0] axis_S_adc1_tdata,
    input  logic              axis_S_adc1_tvalid,
    output logic              axis_S_adc1_tready,
    input  logic              axis_S_adc1_tlast,
    input  logic [DWIDTH-1:0] axis_S_adc2_tdata,
    input  logic              axis_S_adc2_tvalid,
    output logic              axis_S_adc2_tready,
    input  logic              axis_S_adc2_tlast,
    input  logic [DWIDTH-1:0] axis_S_adc3_tdata,
    input  logic              axis_S_adc3_tvalid,
    output logic              axis_S_adc3_tready,
    input  logic              axis_S_adc3_tlast,
    output logic [DWIDTH-1:0] axis_M_merge_tdata,
    output logic              axis_M_merge_tvalid,
    input  logic              axis_M_merge_tready,
    output logic              axis_M_merge_tlast,
    output logic [1:0]        axis_M_merge_tdest,
    output logic              pkt_err
);

    localparam int CW = $clog2(MAX_BEATS + 1);

    beam_state_e       state;
    beam_state_e       state_nxt;
    logic [1:0]        gnt_id;
    logic [1:0]        last_id;
    logic [2:0]        arb_gnt;
    logic [2:0]        s_valid;
    logic [2:0]        s_last;
    logic [2:0]        rdy_vec;
    logic [DWIDTH-1:0] in_data;
    logic              in_valid;
    logic              in_last;
    logic              in_ready;
    logic              take;
    logic              cap_hit;
    logic              eff_last;
    logic [CW-1:0]     beat_cnt;

    assign s_valid = {axis_S_adc3_tvalid, axis_S_adc2_tvalid, axis_S_adc1_tvalid};
    assign s_last  = {axis_S_adc3_tlast, axis_S_adc2_tlast, axis_S_adc1_tlast};

    beam_rr_arb u_arb (
        .valid      (s_valid),
        .mode       (beam_mode_e'(src_sel)),
        .last_grant (last_id),
        .grant      (arb_gnt)
    );

    always_comb begin
        in_data  = '0;
        in_valid = 1'b0;
        in_last  = 1'b0;
        case (gnt_id)
            2'd1: begin
                in_data  = axis_S_adc1_tdata;
                in_valid = s_valid[0];
                in_last  = s_last[0];
            end
            2'd2: begin
                in_data  = axis_S_adc2_tdata;
                in_valid = s_valid[1];
                in_last  = s_last[1];
            end
            2'd3: begin
                in_data  = axis_S_adc3_tdata;
                in_valid = s_valid[2];
                in_last  = s_last[2];
            end
            default: ;
        endcase
    end

    assign in_ready = ~axis_M_merge_tvalid | axis_M_merge_tready;
    assign take     = (state == PASS) & in_valid & in_ready;
    assign cap_hit  = (beat_cnt == CW'(MAX_BEATS - 1));
    assign eff_last = in_last | cap_hit;
    assign rdy_vec  = ((state == PASS) && in_ready) ? id_to_onehot(gnt_id) : 3'b000;

    assign axis_S_adc1_tready = rdy_vec[0];
    assign axis_S_adc2_tready = rdy_vec[1];
    assign axis_S_adc3_tready = rdy_vec[2];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (|arb_gnt) state_nxt = PASS;
            PASS:    if (take && eff_last) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gnt_id              <= 2'd0;
            last_id             <= 2'd3;
            beat_cnt            <= '0;
            axis_M_merge_tdata  <= '0;
            axis_M_merge_tvalid <= 1'b0;
            axis_M_merge_tlast  <= 1'b0;
            axis_M_merge_tdest  <= 2'd0;
            pkt_err             <= 1'b0;
        end else begin
            pkt_err <= 1'b0;
            if (state == IDLE && |arb_gnt) gnt_id <= onehot_to_id(arb_gnt);

            if (take) begin
                axis_M_merge_tdata  <= in_data;
                axis_M_merge_tdest  <= gnt_id;
                axis_M_merge_tvalid <= 1'b1;
                axis_M_merge_tlast  <= eff_last;
                // Error only when the cap, not the source, ends the packet.
                pkt_err             <= cap_hit & ~in_last;
                if (eff_last) begin
                    beat_cnt <= '0;
                    last_id  <= gnt_id;
                end else begin
                    beat_cnt <= beat_cnt + CW'(1);
                end
            end else if (axis_M_merge_tvalid && axis_M_merge_tready) begin
                axis_M_merge_tvalid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_beam_merge.sv
// Randomized bench for beam_merge: a packet-level arbitration model predicts
// the merged stream; per-scenario tasks compare beats, timing and side signals.
module tb_beam_merge;

    localparam int DW = 32;
    localparam int MB = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [1:0]    src_sel;
    logic [DW-1:0] s_data [3];
    logic [2:0]    s_valid;
    logic [2:0]    s_last;
    logic [2:0]    s_ready;
    logic [DW-1:0] m_data;
    logic          m_valid;
    logic          m_ready;
    logic          m_last;
    logic [1:0]    m_dest;
    logic          pkt_err;

    beam_merge #(.DWIDTH(DW), .MAX_BEATS(MB)) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .src_sel             (src_sel),
        .axis_S_adc1_tdata   (s_data[0]),
        .axis_S_adc1_tvalid  (s_valid[0]),
        .axis_S_adc1_tready  (s_ready[0]),
        .axis_S_adc1_tlast   (s_last[0]),
        .axis_S_adc2_tdata   (s_data[1]),
        .axis_S_adc2_tvalid  (s_valid[1]),
        .axis_S_adc2_tready  (s_ready[1]),
        .axis_S_adc2_tlast   (s_last[1]),
        .axis_S_adc3_tdata   (s_data[2]),
        .axis_S_adc3_tvalid  (s_valid[2]),
        .axis_S_adc3_tready  (s_ready[2]),
        .axis_S_adc3_tlast   (s_last[2]),
        .axis_M_merge_tdata  (m_data),
        .axis_M_merge_tvalid (m_valid),
        .axis_M_merge_tready (m_ready),
        .axis_M_merge_tlast  (m_last),
        .axis_M_merge_tdest  (m_dest),
        .pkt_err             (pkt_err)
    );

    always #5 clk = ~clk;

    logic [DW:0]   src_q [3][$];
    logic [DW:0]   mdl_q [3][$];
    logic [DW+2:0] exp_q [$];
    logic [DW+2:0] obs_q [$];
    int            obs_cyc [$];
    int            in_cyc [$];
    int            rdy_pat [$];
    int            cyc, checks, failures;
    int            rdy_mode, multi_rdy, stall_viol, stall_cnt, err_cnt, err_bad;
    int            fire_cnt [3];
    int            model_last, exp_err;
    logic [2:0]    rdy_seen;
    logic [2:0]    fire;
    bit            prev_stall;
    logic [DW+2:0] stall_val;

    // Source drivers and output monitor: sample at negedge, update after posedge.
    initial begin
        m_ready = 1'b1;
        s_valid = '0;
        s_last  = '0;
        for (int i = 0; i < 3; i++) s_data[i] = '0;
        prev_stall = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            fire = '0;
            if (rst_n) begin
                fire = s_valid & s_ready;
                rdy_seen |= s_ready;
                if ($countones(s_ready) > 1) multi_rdy++;
                if (fire != 3'b000) in_cyc.push_back(cyc);
                if (prev_stall && (!m_valid || {m_dest, m_last, m_data} != stall_val)) stall_viol++;
                prev_stall = m_valid && !m_ready;
                if (prev_stall) begin
                    stall_cnt++;
                    stall_val = {m_dest, m_last, m_data};
                end
                if (m_valid && m_ready) begin
                    obs_q.push_back({m_dest, m_last, m_data});
                    obs_cyc.push_back(cyc);
                end
                if (pkt_err) begin
                    err_cnt++;
                    if (!(m_valid && m_last)) err_bad++;
                end
            end else begin
                prev_stall = 1'b0;
            end
            @(posedge clk);
            #1;
            for (int i = 0; i < 3; i++) begin
                if (fire[i] && src_q[i].size() > 0) begin
                    void'(src_q[i].pop_front());
                    fire_cnt[i]++;
                end
                s_valid[i] = (src_q[i].size() > 0);
                if (src_q[i].size() > 0) {s_last[i], s_data[i]} = src_q[i][0];
                else begin
                    s_last[i] = 1'b0;
                    s_data[i] = '0;
                end
            end
            case (rdy_mode)
                1:       m_ready = ($urandom_range(0, 3) != 0);
                2:       m_ready = (rdy_pat.size() > 0) ? (rdy_pat.pop_front() != 0) : 1'b1;
                default: m_ready = 1'b1;
            endcase
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset(input logic [1:0] sel);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            src_q[i].delete();
            mdl_q[i].delete();
            fire_cnt[i] = 0;
        end
        exp_q.delete(); obs_q.delete(); obs_cyc.delete(); in_cyc.delete(); rdy_pat.delete();
        src_sel = sel; rdy_mode = 0; model_last = 3; exp_err = 0;
        multi_rdy = 0; stall_viol = 0; stall_cnt = 0; err_cnt = 0; err_bad = 0; rdy_seen = '0;
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic push_pkt(input int src, input int len);
        logic [DW:0] v;
        for (int b = 0; b < len; b++) begin
            v = {(b == len - 1), $urandom()};
            src_q[src].push_back(v);
            mdl_q[src].push_back(v);
        end
    endtask

    // Whole-packet model: choose a winner among sources with pending beats,
    // move one packet (capped at MB beats) to the expected stream, repeat.
    task automatic model_run(input int mode);
        logic [DW:0] b;
        int          w, n;
        bit          lf;
        forever begin
            w = -1;
            if (mode == 0) begin
                for (int k = 1; k <= 3; k++)
                    if (w < 0 && mdl_q[(model_last - 1 + k) % 3].size() > 0) w = (model_last - 1 + k) % 3;
            end else if (mdl_q[mode - 1].size() > 0) begin
                w = mode - 1;
            end
            if (w < 0) break;
            n = 0;
            do begin
                b = mdl_q[w].pop_front();
                n++;
                lf = b[DW] || (n == MB);
                exp_q.push_back({2'(w + 1), lf, b[DW-1:0]});
            end while (!lf);
            if (n == MB && !b[DW]) exp_err++;
            model_last = w + 1;
        end
    endtask

    task automatic wait_out(input int budget, output bit ok);
        ok = 1'b0;
        for (int k = 0; k < budget; k++) begin
            tick();
            if (obs_q.size() >= exp_q.size()) begin
                ok = 1'b1;
                break;
            end
        end
        repeat (6) tick();
    endtask

    task automatic test_reset();
        do_reset(2'b00);
        push_pkt(0, 4);
        repeat (4) tick();
        rst_n = 1'b0;
        #1;
        checks++; if (s_ready !== 3'b000) begin failures++; $display("FAIL reset_tready got=%b want=000", s_ready); end
        checks++; if (m_valid !== 1'b0) begin failures++; $display("FAIL reset_tvalid got=%b want=0", m_valid); end
        checks++; if (m_last !== 1'b0) begin failures++; $display("FAIL reset_tlast got=%b want=0", m_last); end
        checks++; if (m_dest !== 2'b00) begin failures++; $display("FAIL reset_tdest got=%b want=00", m_dest); end
        checks++; if (m_data !== '0) begin failures++; $display("FAIL reset_tdata got=%h want=0", m_data); end
        checks++; if (pkt_err !== 1'b0) begin failures++; $display("FAIL reset_pkt_err got=%b want=0", pkt_err); end
    endtask

    task automatic test_round_robin();
        bit            ok;
        logic [DW+2:0] got;
        int            dseq [4] = '{1, 2, 3, 1};
        do_reset(2'b00);
        for (int s = 0; s < 3; s++) begin
            push_pkt(s, 4);
            push_pkt(s, 4);
        end
        model_run(0);
        wait_out(200, ok);
        checks++; if (!ok) begin failures++; $display("FAIL rr_timeout got=%0d beats want=%0d", obs_q.size(), exp_q.size()); end
        checks++; if (obs_q.size() != exp_q.size()) begin failures++; $display("FAIL rr_count got=%0d want=%0d", obs_q.size(), exp_q.size()); end
        for (int j = 0; j < exp_q.size(); j++) begin
            checks++;
            got = (j < obs_q.size()) ? obs_q[j] : 'x;
            if (got !== exp_q[j]) begin failures++; $display("FAIL rr_beat[%0d] got=%h want=%h", j, got, exp_q[j]); end
        end
        for (int p = 0; p < 4; p++) begin
            checks++;
            got = (p * 4 < obs_q.size()) ? obs_q[p * 4] : 'x;
            if (got[DW+2:DW+1] !== 2'(dseq[p])) begin failures++; $display("FAIL rr_dest_seq[%0d] got=%b want=%0d", p, got[DW+2:DW+1], dseq[p]); end
        end
        for (int j = 1; j < obs_cyc.size(); j++) begin
            checks++;
            if (obs_cyc[j] - obs_cyc[j-1] != (obs_q[j-1][DW] ? 2 : 1)) begin
                failures++; $display("FAIL rr_spacing[%0d] got=%0d want=%0d", j, obs_cyc[j] - obs_cyc[j-1], obs_q[j-1][DW] ? 2 : 1);
            end
        end
        for (int j = 0; j < obs_cyc.size() && j < in_cyc.size(); j++) begin
            checks++;
            if (obs_cyc[j] != in_cyc[j] + 1) begin failures++; $display("FAIL rr_latency[%0d] got=%0d want=1", j, obs_cyc[j] - in_cyc[j]); end
        end
    endtask

    task automatic test_fixed_mode();
        bit            ok;
        logic [DW+2:0] got;
        do_reset(2'b10);
        push_pkt(0, 3); push_pkt(0, 3);
        push_pkt(1, 3); push_pkt(1, 5);
        push_pkt(2, 2);
        model_run(2);
        wait_out(200, ok);
        checks++; if (!ok) begin failures++; $display("FAIL fixed_timeout got=%0d beats want=%0d", obs_q.size(), exp_q.size()); end
        for (int j = 0; j < exp_q.size(); j++) begin
            checks++;
            got = (j < obs_q.size()) ? obs_q[j] : 'x;
            if (got !== exp_q[j]) begin failures++; $display("FAIL fixed_beat[%0d] got=%h want=%h", j, got, exp_q[j]); end
        end
        checks++; if (obs_q.size() != exp_q.size()) begin failures++; $display("FAIL fixed_count got=%0d want=%0d", obs_q.size(), exp_q.size()); end
        checks++; if (rdy_seen !== 3'b010) begin failures++; $display("FAIL fixed_tready_seen got=%b want=010", rdy_seen); end
    endtask

    task automatic test_stall();
        bit            ok;
        logic [DW+2:0] got;
        do_reset(2'b00);
        rdy_mode = 2;
        rdy_pat = {1, 1, 1, 1, 1, 0, 0, 1};
        for (int k = 0; k < 24; k++) rdy_pat.push_back(int'($urandom_range(0, 1)));
        for (int s = 0; s < 3; s++) push_pkt(s, 5);
        model_run(0);
        wait_out(300, ok);
        checks++; if (!ok) begin failures++; $display("FAIL stall_timeout got=%0d beats want=%0d", obs_q.size(), exp_q.size()); end
        for (int j = 0; j < exp_q.size(); j++) begin
            checks++;
            got = (j < obs_q.size()) ? obs_q[j] : 'x;
            if (got !== exp_q[j]) begin failures++; $display("FAIL stall_beat[%0d] got=%h want=%h", j, got, exp_q[j]); end
        end
        checks++; if (obs_q.size() != exp_q.size()) begin failures++; $display("FAIL stall_count got=%0d want=%0d", obs_q.size(), exp_q.size()); end
        checks++; if (stall_viol != 0) begin failures++; $display("FAIL stall_stability got=%0d changes want=0", stall_viol); end
        checks++; if (stall_cnt == 0) begin failures++; $display("FAIL stall_exercised got=%0d stalls want>0", stall_cnt); end
        checks++; if (multi_rdy != 0) begin failures++; $display("FAIL stall_one_ready got=%0d want=0", multi_rdy); end
    endtask

    task automatic test_max_beats();
        bit            ok;
        logic [DW+2:0] got;
        do_reset(2'b00);
        push_pkt(0, 10);
        model_run(0);
        wait_out(200, ok);
        checks++; if (!ok) begin failures++; $display("FAIL max_timeout got=%0d beats want=%0d", obs_q.size(), exp_q.size()); end
        for (int j = 0; j < exp_q.size(); j++) begin
            checks++;
            got = (j < obs_q.size()) ? obs_q[j] : 'x;
            if (got !== exp_q[j]) begin failures++; $display("FAIL max_beat[%0d] got=%h want=%h", j, got, exp_q[j]); end
        end
        checks++; if (obs_q.size() != 10) begin failures++; $display("FAIL max_count got=%0d want=10", obs_q.size()); end
        checks++; if (err_cnt != 1) begin failures++; $display("FAIL max_pkt_err_pulses got=%0d want=1", err_cnt); end
        checks++; if (err_bad != 0) begin failures++; $display("FAIL max_pkt_err_alignment got=%0d want=0", err_bad); end
    endtask

    task automatic test_reset_mid_packet();
        bit            ok;
        int            partial;
        logic [DW+2:0] got;
        do_reset(2'b00);
        push_pkt(0, 2); push_pkt(1, 6); push_pkt(2, 4);
        ok = 1'b0;
        for (int k = 0; k < 100; k++) begin
            tick();
            if (fire_cnt[1] >= 2) begin ok = 1'b1; break; end
        end
        checks++; if (!ok) begin failures++; $display("FAIL midrst_wait got=%0d beats want=2", fire_cnt[1]); end
        rst_n = 1'b0;
        #1;
        checks++; if ({s_ready, m_valid, m_last, pkt_err} !== 6'b0) begin failures++; $display("FAIL midrst_ctrl got=%b want=000000", {s_ready, m_valid, m_last, pkt_err}); end
        checks++; if ({m_dest, m_data} !== '0) begin failures++; $display("FAIL midrst_data got=%h want=0", {m_dest, m_data}); end
        partial = 0;
        foreach (obs_q[j]) if (obs_q[j][DW+2:DW+1] == 2'd2 && obs_q[j][DW]) partial++;
        checks++; if (partial != 0) begin failures++; $display("FAIL midrst_partial_tlast got=%0d want=0", partial); end
        do_reset(2'b00);
        for (int s = 2; s >= 0; s--) push_pkt(s, 2);
        model_run(0);
        wait_out(200, ok);
        checks++; if (!ok) begin failures++; $display("FAIL midrst_timeout got=%0d beats want=%0d", obs_q.size(), exp_q.size()); end
        got = (obs_q.size() > 0) ? obs_q[0] : 'x;
        checks++; if (got[DW+2:DW+1] !== 2'd1) begin failures++; $display("FAIL midrst_first_grant got=%b want=01", got[DW+2:DW+1]); end
        for (int j = 0; j < exp_q.size(); j++) begin
            checks++;
            got = (j < obs_q.size()) ? obs_q[j] : 'x;
            if (got !== exp_q[j]) begin failures++; $display("FAIL midrst_beat[%0d] got=%h want=%h", j, got, exp_q[j]); end
        end
    endtask

    task automatic test_single_beat();
        bit            ok;
        logic [DW+2:0] got;
        do_reset(2'b00);
        push_pkt(1, 1);
        push_pkt(2, 1);
        model_run(0);
        wait_out(100, ok);
        checks++; if (!ok) begin failures++; $display("FAIL single_timeout got=%0d beats want=2", obs_q.size()); end
        checks++; if (obs_q.size() != 2) begin failures++; $display("FAIL single_count got=%0d want=2", obs_q.size()); end
        for (int j = 0; j < 2; j++) begin
            checks++;
            got = (j < obs_q.size()) ? obs_q[j] : 'x;
            if (got[DW+2:DW] !== {2'(j + 2), 1'b1}) begin failures++; $display("FAIL single_dest_last[%0d] got=%b want=%0d/1", j, got[DW+2:DW], j + 2); end
            if (got !== exp_q[j]) begin failures++; $display("FAIL single_beat[%0d] got=%h want=%h", j, got, exp_q[j]); end
        end
    endtask

    task automatic test_random();
        bit            ok;
        logic [DW+2:0] got;
        logic [1:0]    sel;
        for (int it = 0; it < 8; it++) begin
            sel = 2'($urandom_range(0, 3));
            do_reset(sel);
            rdy_mode = 1;
            for (int s = 0; s < 3; s++)
                for (int p = 0; p < int'($urandom_range(1, 3)); p++) push_pkt(s, int'($urandom_range(1, 12)));
            model_run(int'(sel));
            wait_out(800, ok);
            checks++; if (!ok) begin failures++; $display("FAIL rand%0d_timeout got=%0d beats want=%0d", it, obs_q.size(), exp_q.size()); end
            checks++; if (obs_q.size() != exp_q.size()) begin failures++; $display("FAIL rand%0d_count got=%0d want=%0d", it, obs_q.size(), exp_q.size()); end
            for (int j = 0; j < exp_q.size(); j++) begin
                checks++;
                got = (j < obs_q.size()) ? obs_q[j] : 'x;
                if (got !== exp_q[j]) begin failures++; $display("FAIL rand%0d_beat[%0d] got=%h want=%h", it, j, got, exp_q[j]); end
            end
            checks++; if (err_cnt != exp_err) begin failures++; $display("FAIL rand%0d_pkt_err got=%0d want=%0d", it, err_cnt, exp_err); end
            checks++; if (stall_viol != 0 || multi_rdy != 0) begin failures++; $display("FAIL rand%0d_protocol got=%0d/%0d want=0/0", it, stall_viol, multi_rdy); end
            if (sel != 2'b00) begin
                checks++;
                if ((rdy_seen & ~(3'b001 << (sel - 2'd1))) != 3'b000) begin failures++; $display("FAIL rand%0d_fixed_tready got=%b sel=%0d", it, rdy_seen, sel); end
            end
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        cyc      = 0;
        rdy_mode = 0;
        src_sel  = 2'b00;
        rst_n    = 1'b1;
        #3;
        rst_n    = 1'b0;
        test_reset();
        test_round_robin();
        test_fixed_mode();
        test_stall();
        test_max_beats();
        test_reset_mid_packet();
        test_single_beat();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/beam_merge.md
BEAM_MERGE -- requirements
Module: beam_merge

Interface
REQ-001 Parameter DWIDTH, default 32: data width of every AXIS stream.
REQ-002 Parameter MAX_BEATS, default 2048: maximum beats per output packet before forced termination.
REQ-003 clk  input  1: single clock (300 MHz); all logic is synchronous to its rising edge.
REQ-004 rst_n  input  1: reset, asynchronous and active-low.
REQ-005 src_sel  input  2: arbitration mode; 00 round-robin, 01 source 1 only, 10 source 2 only, 11 source 3 only.
REQ-006 axis_S_adcN_tdata  input  DWIDTH (N=1..3): source N data.
REQ-007 axis_S_adcN_tvalid  input  1: source N valid.
REQ-008 axis_S_adcN_tready  output  1: source N ready.
REQ-009 axis_S_adcN_tlast  input  1: source N end of packet.
REQ-010 axis_M_merge_tdata  output  DWIDTH: merged data.
REQ-011 axis_M_merge_tvalid  output  1: merged valid.
REQ-012 axis_M_merge_tready  input  1: downstream ready.
REQ-013 axis_M_merge_tlast  output  1: merged end of packet.
REQ-014 axis_M_merge_tdest  output  2: originating source of the beat; 01, 10 or 11 for source 1, 2 or 3.
REQ-015 pkt_err  output  1: one-cycle pulse when a packet is force-terminated at MAX_BEATS.

Function
REQ-016 The block SHALL use an FSM with two states, IDLE and PASS, and SHALL arbitrate per packet, never per beat.
REQ-017 IDLE: all source tready SHALL be 0; src_sel is sampled; eligible sources are all three in round-robin mode, otherwise only the selected source.
REQ-018 IDLE, eligible tvalid present: grant SHALL register the winner and go to PASS next cycle; no beat transfers in the IDLE cycle.
REQ-019 Round-robin winner: the first valid source searching cyclically from last-granted + 1.
REQ-020 Fixed mode: the winner is the selected source only when its tvalid is 1.
REQ-021 PASS: only the granted source tready SHALL be high, equal to (~axis_M_merge_tvalid | axis_M_merge_tready); other sources' tready SHALL be 0.
REQ-022 On a granted source handshake, the output register SHALL load, next cycle: tdata; tdest; tvalid=1; tlast = source tlast OR (beat_cnt == MAX_BEATS-1).
REQ-023 When the output handshakes with no new input beat, axis_M_merge_tvalid SHALL clear next cycle.
REQ-024 Input-to-output latency SHALL be 1 cycle.
REQ-025 Full throughput (1 beat/cycle) SHALL be sustained within a packet while downstream tready=1.
REQ-026 Output tdata/tlast/tdest SHALL hold stable while tvalid=1 and tready=0.
REQ-027 beat_cnt: clog2(MAX_BEATS+1) bits; increments on each accepted beat; clears on the effective last beat.
REQ-028 Effective last beat accepted: SHALL return to IDLE, clear beat_cnt, and update last-granted.
REQ-029 Single-beat packet (tlast on the first beat) SHALL be handled identically.
REQ-030 A change of src_sel during PASS SHALL be ignored until the next IDLE.
REQ-031 Forced termination: pkt_err SHALL pulse in the cycle the forced-tlast beat loads; that source's remaining beats form a new packet subject to fresh arbitration.
REQ-032 Minimum inter-packet gap SHALL be one IDLE cycle.

Reset
REQ-033 Reset assertion SHALL immediately force: all tready, axis_M_merge_tvalid, tlast, tdest, tdata and pkt_err to 0; state IDLE; beat_cnt 0; last-granted = source 3, so source 1 has first priority.
REQ-034 Reset mid-packet SHALL discard the in-flight packet; no partial tlast is emitted.
REQ-035 Reset deassertion is synchronized externally to clk.

Structure
REQ-036 Package beam_pkg SHALL hold the mode enum (ROUNDROBIN, SRC1, SRC2, SRC3) and the FSM state enum, shared with the DAC-side demultiplexer.
REQ-037 Round-robin/fixed winner selection SHALL be one sub-module, beam_rr_arb (valid[2:0], mode, last-granted in; one-hot grant out).

Verification
REQ-038 Round-robin, all three sources continuously valid, 4-beat packets, tready=1 -> tdest sequence 01,10,11,01; 4 beats each; tlast on beat 4; one idle cycle between packets.
REQ-039 src_sel=10, sources 1 and 3 valid -> their tready stays 0; only source 2 packets appear with tdest=10.
REQ-040 Downstream tready toggles 1,0,0,1 mid-packet -> no beat lost or duplicated; output is stable during stall.
REQ-041 MAX_BEATS=8, source 1 sends 10 beats with tlast on beat 10 -> output packet of 8 beats with tlast, pkt_err pulses once, then a 2-beat packet.
REQ-042 rst_n low on beat 3 of a packet -> same cycle all outputs are 0; after release, source 1 is granted first.
REQ-043 Single-beat packets on sources 2 and 3 simultaneously, round-robin from reset -> source 2 is granted first, then source 3.
